// File: rtl/tc_decode.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// Negates LSB-first with copy-until-first-one, one bit per clock, valid/ready on both sides.
module tc_decode #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_minneg
);

  localparam int unsigned      CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             seen_q, seen_d;
  logic             osign_q, osign_d;
  logic             minneg_q, minneg_d;
  logic             res_bit;
  logic             last;
  logic [WIDTH-1:0] res_shift;

  // Bits above the first one are inverted only for negative words.
  assign res_bit   = work_q[0] ^ (sign_q & seen_q);
  assign res_shift = {res_bit, res_q[WIDTH-1:1]};
  assign last      = (cnt_q == CntLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      work_q   <= '0;
      res_q    <= '0;
      mag_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      seen_q   <= 1'b0;
      osign_q  <= 1'b0;
      minneg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      res_q    <= res_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      seen_q   <= seen_d;
      osign_q  <= osign_d;
      minneg_q <= minneg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StShift;
      StShift: if (last) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    work_d   = work_q;
    res_d    = res_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    seen_d   = seen_q;
    osign_d  = osign_q;
    minneg_d = minneg_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d = in_data;
          sign_d = in_data[WIDTH-1];
          seen_d = 1'b0;
          cnt_d  = '0;
        end
      end
      StShift: begin
        work_d = work_q >> 1;
        res_d  = res_shift;
        seen_d = seen_q | work_q[0];
        cnt_d  = cnt_q + CntW'(1);
        if (last) begin
          mag_d    = res_shift;
          osign_d  = sign_q;
          minneg_d = sign_q & (res_shift == MinNeg);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
    out_valid  = (state_q == StDone);
    out_sign   = osign_q;
    out_mag    = mag_q;
    out_minneg = minneg_q;
  end

endmodule

// File: tb/tb_tc_decode.sv
// Self-checking bench for tc_decode at WIDTH=8 and WIDTH=2 against an |x| arithmetic model.
module tb_tc_decode;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       v8 = 1'b0, or8 = 1'b0, rdy8, ov8, s8, mn8;
  logic [7:0] d8 = '0, m8;
  logic       v2 = 1'b0, or2 = 1'b0, rdy2, ov2, s2, mn2;
  logic [1:0] d2 = '0, m2;

  tc_decode #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .out_valid(ov8), .out_ready(or8), .out_sign(s8), .out_mag(m8), .out_minneg(mn8)
  );

  tc_decode #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .out_valid(ov2), .out_ready(or2), .out_sign(s2), .out_mag(m2), .out_minneg(mn2)
  );

  // Reference: interpret raw as w-bit two's complement and take |x| with integer arithmetic.
  function automatic void model(input int w, input int raw, output logic s, output int mag,
                                output logic mn);
    int x;
    x   = (raw >= (1 << (w - 1))) ? raw - (1 << w) : raw;
    s   = (x < 0);
    mag = (x < 0) ? -x : x;
    mn  = (x == -(1 << (w - 1)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out8(input bit noise, output int lat);
    lat = 0;
    while (!ov8 && lat < 50) begin
      if (noise) begin
        v8 = 1'($urandom);
        d8 = 8'($urandom);
      end
      tick();
      lat++;
    end
    if (!ov8) lat = -1;
  endtask

  task automatic run8(input logic [7:0] d, input bit noise, output int lat);
    v8 = 1'b1;
    d8 = d;
    tick();
    v8 = 1'b0;
    wait_out8(noise, lat);
  endtask

  task automatic release8();
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({rdy8, ov8, s8, mn8, m8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_w8: got rdy/ov/s/mn/mag=%b want 1000_00000000", {rdy8, ov8, s8, mn8, m8});
    end
    n_cmp++;
    if ({rdy2, ov2, s2, mn2, m2} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_w2: got rdy/ov/s/mn/mag=%b want 100000", {rdy2, ov2, s2, mn2, m2});
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] dir_in  [6] = '{8'h05, 8'hFB, 8'hFF, 8'h00, 8'h80, 8'h7F};
  logic [9:0] dir_exp [6] = '{{1'b0, 8'h05, 1'b0}, {1'b1, 8'h05, 1'b0}, {1'b1, 8'h01, 1'b0},
                              {1'b0, 8'h00, 1'b0}, {1'b1, 8'h80, 1'b1}, {1'b0, 8'h7F, 1'b0}};

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 6; i++) begin
      run8(dir_in[i], 1'b0, lat);
      n_cmp++;
      if (lat !== 8) begin
        n_bad++;
        $display("FAIL directed_latency[%h]: got %0d want 8", dir_in[i], lat);
      end
      n_cmp++;
      if ({s8, m8, mn8} !== dir_exp[i]) begin
        n_bad++;
        $display("FAIL directed_result[%h]: got s/mag/mn=%b want %b", dir_in[i], {s8, m8, mn8},
                 dir_exp[i]);
      end
      release8();
      n_cmp++;
      if ({rdy8, ov8} !== 2'b10) begin
        n_bad++;
        $display("FAIL directed_idle[%h]: got rdy/ov=%b want 10", dir_in[i], {rdy8, ov8});
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, em;
    logic es, emn;
    model(8, 'hA7, es, em, emn);
    run8(8'hA7, 1'b1, lat);
    n_cmp++;
    if (lat !== 8) begin
      n_bad++;
      $display("FAIL bp_latency: got %0d want 8", lat);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({ov8, rdy8, s8, m8, mn8} !== {1'b1, 1'b0, es, 8'(em), emn}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got ov/rdy/s/mag/mn=%b want %b", k,
                 {ov8, rdy8, s8, m8, mn8}, {1'b1, 1'b0, es, 8'(em), emn});
      end
      v8 = 1'($urandom);
      d8 = 8'($urandom);
      tick();
    end
    v8 = 1'b0;
    release8();
    n_cmp++;
    if ({rdy8, ov8, s8, m8, mn8} !== {1'b1, 1'b0, es, 8'(em), emn}) begin
      n_bad++;
      $display("FAIL bp_release_retain: got rdy/ov/s/mag/mn=%b want %b",
               {rdy8, ov8, s8, m8, mn8}, {1'b1, 1'b0, es, 8'(em), emn});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    v8 = 1'b1;
    d8 = 8'hC3;
    tick();
    v8 = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({rdy8, ov8} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_shift_busy: got rdy/ov=%b want 00", {rdy8, ov8});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rdy8, ov8, s8, mn8, m8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL mid_reset: got rdy/ov/s/mn/mag=%b want 1000_00000000",
               {rdy8, ov8, s8, mn8, m8});
    end
    tick();
    rst = 1'b0;
    run8(8'h3D, 1'b0, lat);
    n_cmp++;
    if (lat !== 8 || {s8, m8, mn8} !== {1'b0, 8'h3D, 1'b0}) begin
      n_bad++;
      $display("FAIL after_reset_3d: got lat=%0d s/mag/mn=%b want lat=8 %b", lat,
               {s8, m8, mn8}, {1'b0, 8'h3D, 1'b0});
    end
    release8();
  endtask

  task automatic test_random();
    int lat, em, k;
    logic es, emn;
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      model(8, int'(d), es, em, emn);
      run8(d, 1'b0, lat);
      k = $urandom_range(0, 3);
      repeat (k) tick();
      n_cmp++;
      if (lat !== 8 || {ov8, s8, m8, mn8} !== {1'b1, es, 8'(em), emn}) begin
        n_bad++;
        $display("FAIL random[%h]: got lat=%0d ov/s/mag/mn=%b want lat=8 %b", d, lat,
                 {ov8, s8, m8, mn8}, {1'b1, es, 8'(em), emn});
      end
      release8();
    end
  endtask

  task automatic test_back_to_back8();
    int lat, em, prev;
    logic es, emn;
    prev = 0;
    v8   = 1'b1;
    or8  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d8 = 8'(i - 128);
      model(8, int'(d8), es, em, emn);
      tick();
      wait_out8(1'b0, lat);
      n_cmp++;
      if (lat !== 8 || {s8, m8, mn8} !== {es, 8'(em), emn}) begin
        n_bad++;
        $display("FAIL b2b8[%0d]: got lat=%0d s/mag/mn=%b want lat=8 %b", i - 128, lat,
                 {s8, m8, mn8}, {es, 8'(em), emn});
      end
      if (i > 0) begin
        n_cmp++;
        if (cyc - prev !== 10) begin
          n_bad++;
          $display("FAIL b2b8_period[%0d]: got %0d want 10", i - 128, cyc - prev);
        end
      end
      prev = cyc;
      tick();
    end
    v8  = 1'b0;
    or8 = 1'b0;
  endtask

  task automatic test_width2();
    int lat, em, prev;
    logic es, emn;
    prev = 0;
    v2   = 1'b1;
    or2  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d2 = 2'(i);
      model(2, i, es, em, emn);
      tick();
      lat = 0;
      while (!ov2 && lat < 20) begin
        tick();
        lat++;
      end
      n_cmp++;
      if (lat !== 2 || {ov2, s2, m2, mn2} !== {1'b1, es, 2'(em), emn}) begin
        n_bad++;
        $display("FAIL w2[%b]: got lat=%0d ov/s/mag/mn=%b want lat=2 %b", d2, lat,
                 {ov2, s2, m2, mn2}, {1'b1, es, 2'(em), emn});
      end
      if (i > 0) begin
        n_cmp++;
        if (cyc - prev !== 4) begin
          n_bad++;
          $display("FAIL w2_period[%0d]: got %0d want 4", i, cyc - prev);
        end
      end
      prev = cyc;
      tick();
    end
    v2  = 1'b0;
    or2 = 1'b0;
  endtask

  initial begin
    test_reset();
    tick();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back8();
    test_width2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
